// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: field widths, opcode/funct constants,
// ALUOp and ALUControl encodings, and the ID/EX control payload.
// Optional feature macro: ILLEGAL_INSTR_EN (adds the illegal flag to the payload).
package mips_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned ALUCTL_W = 3;
  localparam int unsigned ALUOP_W  = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BEQ   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluOp_t;

  // Same encodings the Execute-stage ALU consumes
  typedef enum logic [ALUCTL_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluCtl_t;

  typedef struct packed {
    logic    regWrite;
    logic    memtoReg;
    logic    memWrite;
    logic    aluSrc;
    logic    regDst;
    aluCtl_t aluControl;
`ifdef ILLEGAL_INSTR_EN
    logic    illegal;
`endif
  } ctrlE_t;

  // Bubble: every field zero, ALUControl = AND (000)
  localparam ctrlE_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: ALUOp + funct -> ALUControl, plus a funct-valid flag that
// drops only for an R-type with an unrecognised funct.
module alu_decoder
  import mips_pkg::*;
(
  input  aluOp_t             aluOp,
  input  logic [FUNCT_W-1:0] funct,
  output aluCtl_t            aluControl_c,
  output logic               functValid_c
);

  // Select the ALU operation; unknown funct decodes to AND and flags invalid
  always_comb begin
    aluControl_c = ALU_AND;
    functValid_c = 1'b1;
    case (aluOp)
      ALUOP_MEM: aluControl_c = ALU_ADD;
      ALUOP_BEQ: aluControl_c = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: aluControl_c = ALU_ADD;
          FUNCT_SUB: aluControl_c = ALU_SUB;
          FUNCT_AND: aluControl_c = ALU_AND;
          FUNCT_OR:  aluControl_c = ALU_OR;
          FUNCT_SLT: aluControl_c = ALU_SLT;
          default: begin
            aluControl_c = ALU_AND;
            functValid_c = 1'b0;
          end
        endcase
      end
      default: begin
        aluControl_c = ALU_AND;
        functValid_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_unit_de.sv
// Decode-stage control unit: main decode, ALU decode, and the ID/EX control
// register with flush (bubble) and stall (hold).
// Optional feature macro: ILLEGAL_INSTR_EN adds the registered IllegalE output.
module control_unit_de
  import mips_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic [31:0]         InstrD,
  input  logic                StallE,
  input  logic                FlushE,
  output logic                BranchD,
  output logic                JumpD,
  output logic                RegWriteE,
  output logic                MemtoRegE,
  output logic                MemWriteE,
  output logic                ALUSrcE,
  output logic                RegDstE,
  output logic [ALUCTL_W-1:0] ALUControlE
`ifdef ILLEGAL_INSTR_EN
  ,
  output logic                IllegalE
`endif
);

  logic [OP_W-1:0]    opcode;
  logic [FUNCT_W-1:0] funct;
  logic               unusedFields;

  assign opcode       = InstrD[31:26];
  assign funct        = InstrD[5:0];
  assign unusedFields = ^InstrD[25:6];

  logic    regWrite, regDst, aluSrc, branch, memWrite, memtoReg, jump, opValid;
  aluOp_t  aluOp;
  aluCtl_t aluControl;
  logic    functValid;
  logic    illegalD;
  ctrlE_t  ctrlD;
  ctrlE_t  ctrlE;

  // Main decoder: opcode -> datapath controls; unknown opcode is a NOP
  always_comb begin
    regWrite = 1'b0;
    regDst   = 1'b0;
    aluSrc   = 1'b0;
    branch   = 1'b0;
    memWrite = 1'b0;
    memtoReg = 1'b0;
    jump     = 1'b0;
    aluOp    = ALUOP_MEM;
    opValid  = 1'b1;
    case (opcode)
      OP_RTYPE: begin regWrite = 1'b1; regDst = 1'b1; aluOp = ALUOP_FUNCT; end
      OP_LW:    begin regWrite = 1'b1; aluSrc = 1'b1; memtoReg = 1'b1; end
      OP_SW:    begin aluSrc = 1'b1; memWrite = 1'b1; end
      OP_BEQ:   begin branch = 1'b1; aluOp = ALUOP_BEQ; end
      OP_ADDI:  begin regWrite = 1'b1; aluSrc = 1'b1; end
      OP_J:     begin jump = 1'b1; end
      default:  opValid = 1'b0;
    endcase
  end

  alu_decoder uAluDecoder (
    .aluOp        (aluOp),
    .funct        (funct),
    .aluControl_c (aluControl),
    .functValid_c (functValid)
  );

  assign BranchD = branch;
  assign JumpD   = jump;

  // Assemble the E-stage payload; any illegal encoding collapses to a bubble
  always_comb begin
    illegalD = !opValid || !functValid;
    ctrlD    = CTRL_BUBBLE;
    if (!illegalD) begin
      ctrlD.regWrite   = regWrite;
      ctrlD.memtoReg   = memtoReg;
      ctrlD.memWrite   = memWrite;
      ctrlD.aluSrc     = aluSrc;
      ctrlD.regDst     = regDst;
      ctrlD.aluControl = aluControl;
    end
`ifdef ILLEGAL_INSTR_EN
    ctrlD.illegal = illegalD;
`endif
  end

  // ID/EX control register: reset > flush > stall > load
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ctrlE <= CTRL_BUBBLE;
    end else if (FlushE) begin
      ctrlE <= CTRL_BUBBLE;
    end else if (!StallE) begin
      ctrlE <= ctrlD;
    end
  end

  assign RegWriteE   = ctrlE.regWrite;
  assign MemtoRegE   = ctrlE.memtoReg;
  assign MemWriteE   = ctrlE.memWrite;
  assign ALUSrcE     = ctrlE.aluSrc;
  assign RegDstE     = ctrlE.regDst;
  assign ALUControlE = ctrlE.aluControl;
`ifdef ILLEGAL_INSTR_EN
  assign IllegalE    = ctrlE.illegal;
`endif

endmodule

// File: doc/control_unit_de.md
Name: control_unit_de

Overview:
- Decode-stage control unit: the producer side of the ALU control interface.
- Decodes the instruction opcode and funct fields into datapath control signals.
- Drives BranchD/JumpD combinationally in Decode.
- Registers all Execute-stage controls, including ALUControlE, in an ID/EX control pipeline register with stall and flush.

Parameters:
- OP_W, 6, opcode field width (InstrD[31:26])
- FUNCT_W, 6, funct field width (InstrD[5:0])
- ALUCTL_W, 3, ALU control width driven to the Execute-stage ALU

Ports:
- CLK  input  1  single clock, rising edge
- RST  input  1  asynchronous, active-low reset
- InstrD  input  32  Decode-stage instruction
- StallE  input  1  hold the ID/EX control register (multicycle Execute)
- FlushE  input  1  load a bubble into the ID/EX control register (hazard unit)
- BranchD  output  1  beq decoded (combinational)
- JumpD  output  1  j decoded (combinational)
- RegWriteE  output  1  registered
- MemtoRegE  output  1  registered
- MemWriteE  output  1  registered
- ALUSrcE  output  1  registered
- RegDstE  output  1  registered
- ALUControlE  output  3  registered; 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT

Behaviour:
- Reset: RST low asynchronously clears every registered output to 0, including ALUControlE=000. This is the bubble value. Reset has no effect on BranchD/JumpD.
- Main decode (opcode -> RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump, ALUOp):
  - 000000 R-type -> 1,1,0,0,0,0,0, ALUOp=10
  - 100011 lw -> 1,0,1,0,0,1,0, ALUOp=00
  - 101011 sw -> 0,0,1,0,1,0,0, ALUOp=00
  - 000100 beq -> 0,0,0,1,0,0,0, ALUOp=01
  - 001000 addi -> 1,0,1,0,0,0,0, ALUOp=00
  - 000010 j -> 0,0,0,0,0,0,1, ALUOp=00
  - any other opcode -> all zeros (NOP)
- ALU decode:
  - ALUOp 00 -> 010
  - ALUOp 01 -> 110
  - ALUOp 10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111
  - unknown funct -> 000; in that case RegWrite is also forced to 0
- Latency: registered outputs reflect InstrD exactly 1 cycle after the capturing edge.
- Register update on each rising edge, in priority order:
  - RST low: clear (highest priority).
  - Else FlushE=1: load bubble (all zeros). FlushE beats StallE when both are asserted.
  - Else StallE=1: hold current values.
  - Else: load decoded values.
- Reset mid-stream: the register clears immediately, with no edge needed. The first post-reset edge loads from InstrD normally.
- The decode path is pure combinational, with no latches. Every case has a default.

Optional Feature:
- Macro ILLEGAL_INSTR_EN.
- Defined:
  - Adds port IllegalE (output, 1), registered alongside the other E-stage controls.
  - IllegalE=1 when the opcode is undefined, or the opcode is R-type with an undefined funct.
  - Cleared by reset and flush; held by stall.
  - All other controls still decode to NOP.
- Undefined:
  - No IllegalE port.
  - Illegal instructions silently become NOPs.

Decomposition:
- Shared package mips_pkg:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALUOp encodings
  - ALUControl encodings: ADD/SUB/AND/OR/SLT. The ALU uses these same encodings.
- Sub-module alu_decoder (combinational: ALUOp, funct -> ALUControl, funct_valid), instantiated once.
- Main decoder, flush/stall muxing and ID/EX register stay in the top.

Test Plan:
- Reset: RST=0 mid-cycle with a valid R-add in flight -> all E outputs 0 immediately. Release, InstrD=0x00221820 (add) -> after 1 edge RegWriteE=1, RegDstE=1, ALUControlE=010.
- Opcode sweep: lw 0x8C220004 -> ALUSrcE=1, MemtoRegE=1, ALUControlE=010. sw 0xAC220004 -> MemWriteE=1, RegWriteE=0. beq 0x10220002 -> BranchD=1 same cycle, ALUControlE=110 next. j 0x08000010 -> JumpD=1, E controls 0.
- Funct sweep: sub 0x00221822 -> 110. and ..24 -> 000. or ..25 -> 001. slt ..2A -> 111. Funct 0x3F -> ALUControlE=000, RegWriteE=0.
- Stall: load add, assert StallE 3 cycles while InstrD=sw -> outputs stay add values. Deassert -> sw values after next edge.
- Flush vs stall: StallE=1, FlushE=1 together with InstrD=lw -> all outputs 0 after edge. FlushE alone -> bubble for exactly one cycle.
- ILLEGAL_INSTR_EN builds: opcode 0x3F -> IllegalE=1 and all controls 0 next cycle; FlushE clears it. Without the macro: same controls, and the port is absent.
